// File: rtl/mod_pkg.sv
// Shared constants and helpers for the open-drain beacon.
package mod_pkg;

  localparam int EXT_CNT_W = 8;

  function automatic int clog2(input int value);
    for (int r = 0; r < 32; r++) begin
      if ((1 << r) >= value) return r;
    end
    return 32;
  endfunction

endpackage

// File: rtl/od_sync2.sv
// Two-flop synchroniser for the shared wire; resets to the idle (pulled-up) level.
module od_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/mod.sv
// Open-drain beacon: pulls a wired-AND line low LOW_W cycles every PERIOD cycles
// and re-aligns its phase to falling edges driven by other beacons on the wire.
module mod
  import mod_pkg::*;
#(
  parameter int PERIOD = 16,
  parameter int LOW_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  inout  tri                   line,
  output logic                 pulse_out,
  output logic                 sync_evt,
  output logic [EXT_CNT_W-1:0] ext_cnt
);

  localparam int CNT_W = clog2(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] LOW_END   = CNT_W'(LOW_W);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(LOW_W + 3);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 drive_low_q, drive_low_d;
  logic                 pulse_q, sync_q;
  logic                 line_s, line_prev_q;
  logic                 ext_fall, realign;
  logic [EXT_CNT_W-1:0] ext_cnt_q, ext_cnt_d;

  od_sync2 u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (line),
    .q_o   (line_s)
  );

  // The own pulse echoes back through the synchroniser while cnt is still small;
  // falls seen inside that window are ignored.
  assign ext_fall = line_prev_q & ~line_s;
  assign realign  = en & ext_fall & (cnt_q >= BLANK_END);

  always_comb begin
    cnt_d = '0;
    if (en && !realign) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    drive_low_d = en & (cnt_d < LOW_END);
    ext_cnt_d   = ext_cnt_q;
    if (realign && (ext_cnt_q != {EXT_CNT_W{1'b1}})) begin
      ext_cnt_d = ext_cnt_q + EXT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      drive_low_q <= 1'b0;
      pulse_q     <= 1'b0;
      sync_q      <= 1'b0;
      ext_cnt_q   <= '0;
      line_prev_q <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      drive_low_q <= drive_low_d;
      pulse_q     <= drive_low_d & ~drive_low_q;
      sync_q      <= realign;
      ext_cnt_q   <= ext_cnt_d;
      line_prev_q <= line_s;
    end
  end

  assign line      = drive_low_q ? 1'b0 : 1'bz;
  assign pulse_out = pulse_q;
  assign sync_evt  = sync_q;
  assign ext_cnt   = ext_cnt_q;

endmodule

// File: tb/tb_mod.sv
// Directed bench for the open-drain beacon: default and PERIOD=42 instances on separate wires.
module tb_mod;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ext_a = 1'b0;
  tri         line_a;
  tri         line_b;
  logic       pa, sa, pb, sb;
  logic [7:0] ca, cb;

  int n_vec = 0;
  int n_bad = 0;

  pullup (line_a);
  pullup (line_b);
  assign line_a = ext_a ? 1'b0 : 1'bz;

  mod dut_a (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .line      (line_a),
    .pulse_out (pa),
    .sync_evt  (sa),
    .ext_cnt   (ca)
  );

  mod #(.PERIOD(42)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .line      (line_b),
    .pulse_out (pb),
    .sync_evt  (sb),
    .ext_cnt   (cb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Negedges until pulse_out of instance A is seen; -1 if it never comes.
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pa && n < 100);
    if (!pa) n = -1;
  endtask

  initial begin
    int   bad, bad_la, bad_pa, bad_lb, bad_pb, syn, n, nsync;
    logic e_la, e_pa, e_lb, e_pb;
    bad = 0; bad_la = 0; bad_pa = 0; bad_lb = 0; bad_pb = 0; syn = 0; nsync = 0;

    repeat (3) @(negedge clk);
    chk("rst_line", int'(line_a), 1);
    chk("rst_pulse", int'(pa), 0);
    chk("rst_sync", int'(sa), 0);
    chk("rst_extcnt", int'(ca), 0);

    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (line_a !== 1'b1 || pa || sa || ca != 0 || line_b !== 1'b1 || pb || sb || cb != 0)
        bad++;
    end
    chk("idle_en0", bad, 0);

    // Free run: k counts negedges after en goes high; the very first pulse is one
    // cycle wide because cnt leaves 0 on the enabling edge.
    en = 1'b1;
    for (int k = 1; k <= 1008; k++) begin
      @(negedge clk);
      e_la = !(k == 1 || (k % 16) < 2);
      e_pa = (k == 1 || (k % 16) == 0);
      e_lb = !(k == 1 || (k % 42) < 2);
      e_pb = (k == 1 || (k % 42) == 0);
      if (line_a !== e_la) bad_la++;
      if (pa !== e_pa) bad_pa++;
      if (line_b !== e_lb) bad_lb++;
      if (pb !== e_pb) bad_pb++;
      if (sa || sb || ca != 0 || cb != 0) syn++;
    end
    chk("free16_line", bad_la, 0);
    chk("free16_pulse", bad_pa, 0);
    chk("free42_line", bad_lb, 0);
    chk("free42_pulse", bad_pb, 0);
    chk("echo_blank", syn, 0);

    // cnt of A is 0 here; pull the line low for 3 cycles starting at cnt=9.
    repeat (9) @(negedge clk);
    ext_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("realign_early", int'(sa), 0);
    @(negedge clk);
    ext_a = 1'b0;
    chk("realign_sync", int'(sa), 1);
    chk("realign_extcnt", int'(ca), 1);
    chk("realign_pulse", int'(pa), 1);
    chk("realign_low0", int'(line_a), 0);
    @(negedge clk);
    chk("realign_sync_once", int'(sa), 0);
    chk("realign_low1", int'(line_a), 0);
    @(negedge clk);
    chk("realign_release", int'(line_a), 1);
    wait_pulse(n);
    chk("realign_gap1", n, 14);
    wait_pulse(n);
    chk("realign_gap2", n, 16);

    // Saturation: each injection lands at cnt=8 and restarts the counter.
    for (int i = 0; i < 300; i++) begin
      repeat (8) @(negedge clk);
      ext_a = 1'b1;
      repeat (3) @(negedge clk);
      ext_a = 1'b0;
      if (sa && pa) nsync++;
      if (i == 99) chk("sat_mid", int'(ca), 101);
    end
    chk("sat_syncs", nsync, 300);
    chk("sat_extcnt", int'(ca), 255);

    chk("pre_rst_low", int'(line_a), 0);
    rst = 1'b1;
    #1;
    chk("arst_line", int'(line_a), 1);
    chk("arst_extcnt", int'(ca), 0);
    chk("arst_pulse", int'(pa), 0);

    @(negedge clk);
    rst = 1'b0;
    wait_pulse(n);
    chk("post_rst_first", n, 1);
    wait_pulse(n);
    chk("post_rst_period", n, 15);
    chk("en_fall_low", int'(line_a), 0);
    en = 1'b0;
    @(negedge clk);
    chk("en_fall_release", int'(line_a), 1);
    chk("en_fall_pulse", int'(pa), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mod.md
Name: mod

Overview:
- Parameterised open-drain beacon for a shared single-wire, wired-AND line (external pull-up on the net).
- Pulls the line low for LOW_W cycles once every PERIOD cycles.
- Watches the line for pulses from other devices and re-aligns its own period to them, so all beacons on one wire converge to a common phase.
- Sits at the leaf level and is instantiated per wire, e.g. with PERIOD overridden to 42.

Parameters:
- PERIOD, 16, beacon period in clk cycles; legal range LOW_W+4 .. 65535.
- LOW_W, 2, width of the low pulse in clk cycles; legal range 1 .. PERIOD-4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  beacon enable.
- line  inout  1  open-drain wire; driven 1'b0 or released to 'z, never driven 1.
- pulse_out  output  1  one-cycle strobe when the own low pulse starts.
- sync_evt  output  1  one-cycle strobe when re-aligned to an external pulse.
- ext_cnt  output  8  count of re-alignments, saturating.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, drive_low=0 (line='z'), pulse_out=0, sync_evt=0, ext_cnt=0.
  - Both synchroniser flops and line_prev = 1.
- Line input path:
  - line_s = line through a 2-flop synchroniser; 2-cycle latency.
  - line_prev = line_s delayed by one cycle.
  - ext_fall = line_prev & ~line_s.
- Counter: cnt has width clog2(PERIOD).
- en=0:
  - cnt forced to 0, drive_low=0, no strobes.
  - ext_cnt holds its value.
  - Synchronisers keep running.
- en=1, normal case: next_cnt = (cnt==PERIOD-1) ? 0 : cnt+1.
- Blanking window: cnt < LOW_W+3. This covers the echo of the module's own pulse through the synchroniser.
- External re-align:
  - Trigger: ext_fall=1, en=1, and cnt outside the blanking window.
  - Then next_cnt=0 and sync_evt=1.
  - ext_cnt increments, saturating at 255.
  - A re-align overrides the normal wrap.
- Drive: drive_low is registered as en & (next_cnt < LOW_W).
  - line = drive_low ? 1'b0 : 1'bz.
  - pulse_out=1 in the cycle where drive_low rises from 0 to 1.
- Timing after reset release with en=1:
  - First cycle: cnt 0->1 and drive_low=1 immediately (next_cnt=1 < LOW_W=2).
  - pulse_out fires 1 cycle after en is first sampled high.
  - Thereafter the pulse repeats every PERIOD cycles.
- Simultaneous events:
  - ext_fall inside the blanking window is ignored: no strobe, no count.
  - en falling during a pulse releases the line on the next edge.
  - rst mid-pulse releases the line immediately (async).
- All outputs other than line are registered.

Decomposition:
- Shared package: function clog2 and the constant EXT_CNT_W=8.
- One sub-module, od_sync2: a 2-flop synchroniser with an async-reset value of 1.
- Counter, blanking, drive and statistics logic stay in mod.

Test Plan:
- Reset and idle: rst=1, then 0 with en=0 -> line='z' and all outputs 0 for 100 cycles.
- Free-running, defaults (PERIOD=16, LOW_W=2):
  - Stimulus: en=1 and no external driver (pull-up only).
  - Required: line low for exactly 2 cycles every 16 cycles.
  - Required: pulse_out every 16 cycles, sync_evt never, ext_cnt=0.
- PERIOD=42 override: en=1 -> pulse spacing is exactly 42 cycles and the low width is 2.
- External re-align:
  - Stimulus: pull the line low for 3 cycles while cnt=9.
  - Required: sync_evt asserts 2-3 cycles later, ext_cnt=1, and cnt restarts at 0.
  - Required: the own pulse starts aligned with the restart, and subsequent pulses are 16 cycles apart from it.
- Echo blanking: the module's own pulse returning through the synchroniser never sets sync_evt; ext_cnt stays 0 over 1000 cycles.
- Saturation and async reset:
  - Stimulus: inject 300 external pulses outside the blanking window.
  - Required: ext_cnt=255.
  - Stimulus: assert rst mid-pulse.
  - Required: line='z' and ext_cnt=0 before the next clk edge.
